// File: rtl/alu_sweep_misr.sv
// Exhaustive 4-bit ALU sweep: drives all 4096 {sel,b,a} vectors in order and
// compresses the LAT-delayed responses into a 16-bit CRC-CCITT style MISR.
module alu_sweep_misr #(
   parameter int          LAT  = 1,
   parameter logic [15:0] SEED = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        start,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [3:0]  alu_sel,
   input  logic [7:0]  alu_resp,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic [12:0] resp_count,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [11:0] r_idx;
   logic [15:0] r_sig;
   logic [12:0] r_cnt;
   logic        w_launch;
   logic        w_issue;
   logic        w_last;
   logic        w_sample;
   logic [15:0] w_sig_nxt;

   // start is a one-shot request honoured only while not busy; ena gates every update.
   assign w_launch  = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
   assign w_issue   = (r_state == S_RUN);
   assign w_last    = w_issue && (r_idx == 12'hFFF);
   assign w_sig_nxt = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000)
                      ^ {8'h00, alu_resp};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_cnt == 13'd4096) w_state_nxt = S_DONE;
         S_DONE:  if (start) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (ena) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx <= 12'h000;
      end else if (ena) begin
         if (w_launch) begin
            r_idx <= 12'h000;
         end else if (w_issue && !w_last) begin
            r_idx <= r_idx + 12'h001;
         end
      end
   end

   // The issue cycle itself is the first pipeline stage, so only LAT-1 flops are needed.
   generate
      if (LAT == 1) begin : g_lat1
         assign w_sample = w_issue;
      end else begin : g_latn
         logic [LAT-2:0] r_vld;
         logic [LAT-2:0] w_vld_in;
         assign w_vld_in = (LAT-1)'(w_issue);
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_vld <= '0;
            end else if (ena) begin
               if (w_launch) begin
                  r_vld <= '0;
               end else begin
                  r_vld <= (r_vld << 1) | w_vld_in;
               end
            end
         end
         assign w_sample = r_vld[LAT-2];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sig <= SEED;
         r_cnt <= 13'd0;
      end else if (ena) begin
         if (w_launch) begin
            r_sig <= SEED;
            r_cnt <= 13'd0;
         end else if (w_sample) begin
            r_sig <= w_sig_nxt;
            r_cnt <= r_cnt + 13'd1;
         end
      end
   end

   always_comb begin
      alu_a   = 4'h0;
      alu_b   = 4'h0;
      alu_sel = 4'h0;
      if (w_issue) begin
         alu_a   = r_idx[3:0];
         alu_b   = r_idx[7:4];
         alu_sel = r_idx[11:8];
      end
   end

   assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done       = (r_state == S_DONE);
   assign signature  = r_sig;
   assign resp_count = r_cnt;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_sweep_misr.sv
// Directed bench for alu_sweep_misr: a LAT=1 instance fed by a combinational
// ALU model and a LAT=3 instance fed through two response registers.
module tb_alu_sweep_misr;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic        start1 = 1'b0;
   logic        start3 = 1'b0;
   logic        fault = 1'b0;

   logic [3:0]  a1, b1, sel1, a3, b3, sel3;
   logic [7:0]  resp1, resp3, p1, p2;
   logic        busy1, done1, busy3, done3;
   logic [15:0] sig1, sig3;
   logic [12:0] cnt1, cnt3;
   logic [1:0]  st1, st3;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] exp_full, exp_fault, exp_256;

   always #5 clk = ~clk;

   alu_sweep_misr #(.LAT(1), .SEED(16'hFFFF)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1),
      .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .alu_resp(resp1),
      .busy(busy1), .done(done1), .signature(sig1), .resp_count(cnt1),
      .dbg_state(st1)
   );

   alu_sweep_misr #(.LAT(3), .SEED(16'hFFFF)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start3),
      .alu_a(a3), .alu_b(b3), .alu_sel(sel3), .alu_resp(resp3),
      .busy(busy3), .done(done3), .signature(sig3), .resp_count(cnt3),
      .dbg_state(st3)
   );

   function automatic logic [7:0] alu_model(input logic [11:0] v);
      logic [3:0] a, b, o;
      logic [4:0] t;
      logic       c, ov;
      a = v[3:0]; b = v[7:4];
      c = 1'b0; ov = 1'b0; t = 5'd0;
      case (v[11:8])
         4'd0:  begin t = {1'b0, a} + {1'b0, b}; o = t[3:0]; c = t[4];
                      ov = (a[3] == b[3]) && (o[3] != a[3]); end
         4'd1:  begin t = {1'b0, a} - {1'b0, b}; o = t[3:0]; c = t[4];
                      ov = (a[3] != b[3]) && (o[3] != a[3]); end
         4'd2:  o = a & b;
         4'd3:  o = a | b;
         4'd4:  o = a ^ b;
         4'd5:  o = ~a;
         4'd6:  begin o = {a[2:0], 1'b0}; c = a[3]; end
         4'd7:  begin o = {1'b0, a[3:1]}; c = a[0]; end
         4'd8:  begin t = {1'b0, a} + 5'd1; o = t[3:0]; c = t[4]; end
         4'd9:  begin t = {1'b0, a} - 5'd1; o = t[3:0]; c = t[4]; end
         4'd10: o = ~(a & b);
         4'd11: o = ~(a | b);
         4'd12: o = b;
         4'd13: o = a;
         4'd14: o = {a[0], a[3:1]};
         default: o = 4'h0;
      endcase
      return {c, (o == 4'h0), o[3], ov, o};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, r};
   endfunction

   function automatic logic [15:0] fold_model(input int n, input bit zfault);
      logic [15:0] s;
      logic [7:0]  r;
      s = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         r = alu_model(12'(i));
         if (zfault) r[6] = 1'b0;
         s = misr_step(s, r);
      end
      return s;
   endfunction

   // Combinational ALU for the LAT=1 instance, with an optional stuck-at-0 Zero flag.
   assign resp1 = alu_model({sel1, b1, a1}) & {1'b1, ~fault, 6'h3F};

   always @(posedge clk) begin
      if (ena) begin
         p1 <= alu_model({sel3, b3, a3});
         p2 <= p1;
      end
   end
   assign resp3 = p2;

   task automatic launch1();
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
   endtask

   task automatic wait_idle1(output int nbusy, output bit tmo);
      nbusy = 0; tmo = 1'b1;
      for (int k = 0; k < 6000; k++) begin
         if (!busy1) begin tmo = 1'b0; break; end
         nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic wait_drive1(input logic [11:0] v, output bit tmo);
      tmo = 1'b1;
      for (int k = 0; k < 5000; k++) begin
         if ({sel1, b1, a1} == v) begin tmo = 1'b0; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; start1 = 1'b0; start3 = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (sig1 !== 16'hFFFF) begin n_bad++; $display("FAIL reset_sig: got %h want ffff", sig1); end
      n_vec++; if (cnt1 !== 13'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", cnt1); end
      n_vec++; if ({busy1, done1} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {busy1, done1}); end
      n_vec++; if ({sel1, b1, a1} !== 12'h000) begin n_bad++; $display("FAIL reset_drive: got %h want 000", {sel1, b1, a1}); end
      n_vec++; if (st1 !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st1); end
      n_vec++; if ({sig3, cnt3, busy3, done3, st3} !== {16'hFFFF, 13'd0, 2'b00, 2'd0}) begin
         n_bad++; $display("FAIL reset_lat3: got sig %h cnt %0d busy %b done %b st %0d", sig3, cnt3, busy3, done3, st3); end
      start1 = 1'b1;
      @(negedge clk);
      n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_over_start: got busy %b want 0", busy1); end
      start1 = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_sweep_lat1();
      int n; bit ok, tmo; logic [11:0] first, last, drv, ex;
      n = 0; ok = 1'b1; tmo = 1'b1; first = 12'hAAA; last = 12'hAAA;
      launch1();
      for (int k = 0; k < 6000; k++) begin
         if (!busy1) begin tmo = 1'b0; break; end
         drv = {sel1, b1, a1};
         ex  = (n < 4096) ? 12'(n) : 12'h000;
         if (drv !== ex) ok = 1'b0;
         if (n == 0) first = drv;
         if (n == 4095) last = drv;
         n++;
         @(negedge clk);
      end
      n_vec++; if (tmo) begin n_bad++; $display("FAIL sweep1_timeout: busy still %b after 6000 cycles", busy1); end
      n_vec++; if (n !== 4097) begin n_bad++; $display("FAIL sweep1_busy_cycles: got %0d want 4097", n); end
      n_vec++; if (first !== 12'h000) begin n_bad++; $display("FAIL sweep1_first: got %h want 000", first); end
      n_vec++; if (last !== 12'hFFF) begin n_bad++; $display("FAIL sweep1_last: got %h want fff", last); end
      n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sweep1_order: got out-of-order drive, want 0..fff then 0"); end
      n_vec++; if (cnt1 !== 13'd4096) begin n_bad++; $display("FAIL sweep1_cnt: got %0d want 4096", cnt1); end
      n_vec++; if (done1 !== 1'b1) begin n_bad++; $display("FAIL sweep1_done: got %b want 1", done1); end
      n_vec++; if (sig1 !== exp_full) begin n_bad++; $display("FAIL sweep1_sig: got %h want %h", sig1, exp_full); end
      repeat (5) @(negedge clk);
      n_vec++; if ({sig1, cnt1, done1} !== {exp_full, 13'd4096, 1'b1}) begin
         n_bad++; $display("FAIL done_hold: got sig %h cnt %0d done %b want %h 4096 1", sig1, cnt1, done1, exp_full); end
   endtask

   task automatic test_fault_restart();
      int nb; bit tmo;
      fault = 1'b1;
      launch1();
      n_vec++; if ({sig1, cnt1, done1, busy1} !== {16'hFFFF, 13'd0, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL restart_from_done: got sig %h cnt %0d done %b busy %b", sig1, cnt1, done1, busy1); end
      wait_idle1(nb, tmo);
      n_vec++; if (tmo) begin n_bad++; $display("FAIL fault_timeout: busy still set"); end
      n_vec++; if (sig1 !== exp_fault) begin n_bad++; $display("FAIL fault_sig: got %h want %h", sig1, exp_fault); end
      n_vec++; if (sig1 === exp_full) begin n_bad++; $display("FAIL fault_detect: got %h want value differing from %h", sig1, exp_full); end
      fault = 1'b0;
   endtask

   task automatic test_lat3();
      int nb; bit tmo;
      nb = 0; tmo = 1'b1;
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      for (int k = 0; k < 6000; k++) begin
         if (!busy3) begin tmo = 1'b0; break; end
         nb++;
         @(negedge clk);
      end
      n_vec++; if (tmo) begin n_bad++; $display("FAIL lat3_timeout: busy still set"); end
      n_vec++; if (nb !== 4099) begin n_bad++; $display("FAIL lat3_busy_cycles: got %0d want 4099", nb); end
      n_vec++; if (cnt3 !== 13'd4096) begin n_bad++; $display("FAIL lat3_cnt: got %0d want 4096", cnt3); end
      n_vec++; if (done3 !== 1'b1) begin n_bad++; $display("FAIL lat3_done: got %b want 1", done3); end
      n_vec++; if (sig3 !== exp_full) begin n_bad++; $display("FAIL lat3_sig: got %h want %h", sig3, exp_full); end
   endtask

   task automatic test_stall();
      int nb; bit tmo;
      launch1();
      wait_drive1(12'h100, tmo);
      n_vec++; if (tmo) begin n_bad++; $display("FAIL stall_reach: drive 100 not seen, got %h", {sel1, b1, a1}); end
      ena = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_vec++; if ({sel1, b1, a1, cnt1, sig1} !== {12'h100, 13'h100, exp_256}) begin
            n_bad++; $display("FAIL stall_freeze: got drive %h cnt %h sig %h want 100 100 %h",
                              {sel1, b1, a1}, cnt1, sig1, exp_256); end
      end
      ena = 1'b1;
      wait_idle1(nb, tmo);
      n_vec++; if (tmo) begin n_bad++; $display("FAIL stall_timeout: busy still set"); end
      n_vec++; if ({sig1, cnt1, done1} !== {exp_full, 13'd4096, 1'b1}) begin
         n_bad++; $display("FAIL stall_final: got sig %h cnt %0d done %b want %h 4096 1", sig1, cnt1, done1, exp_full); end
   endtask

   task automatic test_restart_abort();
      int nb; bit tmo;
      launch1();
      wait_drive1(12'h200, tmo);
      n_vec++; if (tmo) begin n_bad++; $display("FAIL abort_reach200: drive 200 not seen"); end
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      n_vec++; if ({busy1, sel1, b1, a1, cnt1} !== {1'b1, 12'h201, 13'h201}) begin
         n_bad++; $display("FAIL start_ignored: got busy %b drive %h cnt %h want 1 201 201", busy1, {sel1, b1, a1}, cnt1); end
      wait_drive1(12'h800, tmo);
      n_vec++; if (tmo) begin n_bad++; $display("FAIL abort_reach800: drive 800 not seen"); end
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++; if ({busy1, done1, st1, sig1, cnt1, sel1, b1, a1} !== {2'b00, 2'd0, 16'hFFFF, 13'd0, 12'h000}) begin
         n_bad++; $display("FAIL abort_reset: got busy %b done %b st %0d sig %h cnt %0d drive %h",
                           busy1, done1, st1, sig1, cnt1, {sel1, b1, a1}); end
      rst_n = 1'b1;
      launch1();
      wait_idle1(nb, tmo);
      n_vec++; if (tmo) begin n_bad++; $display("FAIL rerun_timeout: busy still set"); end
      n_vec++; if (nb !== 4097) begin n_bad++; $display("FAIL rerun_busy_cycles: got %0d want 4097", nb); end
      n_vec++; if ({sig1, cnt1, done1} !== {exp_full, 13'd4096, 1'b1}) begin
         n_bad++; $display("FAIL rerun_final: got sig %h cnt %0d done %b want %h 4096 1", sig1, cnt1, done1, exp_full); end
   endtask

   initial begin
      exp_full  = fold_model(4096, 1'b0);
      exp_fault = fold_model(4096, 1'b1);
      exp_256   = fold_model(256, 1'b0);
      test_reset();
      test_sweep_lat1();
      test_fault_restart();
      test_lat3();
      test_stall();
      test_restart_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
